// File: rtl/srrc_pkg.sv
// Shared types and helpers for the SRRC polyphase interpolator.
// Symbol encoding, coefficient format, FSM states and the output saturator.
package srrc_pkg;

    localparam int SRRC_CW   = 16;
    localparam int SRRC_FRAC = 14;

    localparam logic [1:0] SYM_ZERO = 2'b00;
    localparam logic [1:0] SYM_P1   = 2'b01;
    localparam logic [1:0] SYM_M1   = 2'b11;
    localparam logic [1:0] SYM_M2   = 2'b10;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    // Clamp v into the signed range of a w-bit word; caller truncates to w bits.
    function automatic logic signed [63:0] sat_to(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/srrc_coef_bank.sv
// Programmable tap register file with a phase-indexed polyphase read port.
// Writes land next cycle; reads are combinational; no backpressure.
module srrc_coef_bank
    import srrc_pkg::*;
#(
    parameter int  NTAPS = 33,
    parameter int  OSR   = 4,
    parameter int  CW    = SRRC_CW,
    localparam int NPH   = (NTAPS + OSR - 1) / OSR,
    localparam int PW    = $clog2(OSR),
    localparam int TAW   = $clog2(NTAPS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic [TAW-1:0]           addr,
    input  logic [CW-1:0]            wdata,
    input  logic [PW-1:0]            phase,
    output logic [NPH-1:0][CW-1:0]   taps
);

    localparam int DEPTH = NPH * OSR;
    localparam int IW    = $clog2(DEPTH);

    // Entries at NTAPS and above are never written, so they read back as the zero padding.
    logic [CW-1:0] coef [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                coef[i] <= '0;
            end
        end else if (we && (32'(addr) < NTAPS)) begin
            coef[IW'(addr)] <= wdata;
        end
    end

    for (genvar k = 0; k < NPH; k++) begin : g_rd
        localparam logic [IW-1:0] BASE = IW'(OSR * k);
        assign taps[k] = coef[BASE + IW'(phase)];
    end

endmodule

// File: rtl/srrc_interp.sv
// Polyphase SRRC interpolator: one 2-bit symbol in, OSR filtered samples out.
// Latency: first sample valid the cycle after the symbol is accepted.
// Backpressure: out_ready low holds sample and phase; in_ready follows out_ready on the last phase.
module srrc_interp
    import srrc_pkg::*;
#(
    parameter int  NTAPS = 33,
    parameter int  OSR   = 4,
    parameter int  CW    = SRRC_CW,
    parameter int  OW    = 18,
    localparam int NPH   = (NTAPS + OSR - 1) / OSR,
    localparam int AW    = CW + 2 + $clog2(NPH),
    localparam int PW    = $clog2(OSR),
    localparam int TAW   = $clog2(NTAPS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_sym,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OW-1:0]   out_data,
    input  logic            coef_we,
    input  logic [TAW-1:0]  coef_addr,
    input  logic [CW-1:0]   coef_wdata,
    input  logic            flush
);

    state_t                  state, state_nx;
    logic [PW-1:0]           phase, phase_nx;
    logic [NPH-1:0][1:0]     dl;
    logic [NPH-1:0][CW-1:0]  taps;
    logic                    shift, clear, last_ph;
    logic signed [AW-1:0]    acc, term;

    srrc_coef_bank #(
        .NTAPS (NTAPS),
        .OSR   (OSR),
        .CW    (CW)
    ) u_coef (
        .clk   (clk),
        .reset (reset),
        .we    (coef_we),
        .addr  (coef_addr),
        .wdata (coef_wdata),
        .phase (phase),
        .taps  (taps)
    );

    assign last_ph   = (phase == PW'(OSR - 1));
    assign out_valid = (state == RUN);
    // Gated by flush so a symbol dropped by flush is never handshaken.
    assign in_ready  = !flush && ((state == IDLE) || (last_ph && out_ready));

    always_comb begin
        state_nx = state;
        phase_nx = phase;
        shift    = 1'b0;
        clear    = 1'b0;
        if (flush) begin
            state_nx = IDLE;
            phase_nx = '0;
            clear    = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shift    = 1'b1;
                        phase_nx = '0;
                        state_nx = RUN;
                    end
                end
                RUN: begin
                    if (out_ready) begin
                        if (!last_ph) begin
                            phase_nx = phase + 1'b1;
                        end else begin
                            phase_nx = '0;
                            if (in_valid) begin
                                shift = 1'b1;
                            end else begin
                                state_nx = IDLE;
                            end
                        end
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            phase <= '0;
            dl    <= '0;
        end else begin
            state <= state_nx;
            phase <= phase_nx;
            if (clear) begin
                dl <= '0;
            end else if (shift) begin
                dl <= {dl[NPH-2:0], in_sym};
            end
        end
    end

    // Symbols are limited to {0, +1, -1, -2}, so each tap is add, subtract or subtract-doubled.
    always_comb begin
        acc  = '0;
        term = '0;
        for (int k = 0; k < NPH; k++) begin
            term = AW'($signed(taps[k]));
            case (dl[k])
                SYM_P1:  acc = acc + term;
                SYM_M1:  acc = acc - term;
                SYM_M2:  acc = acc - (term <<< 1);
                default: ;
            endcase
        end
    end

    assign out_data = out_valid ? OW'(sat_to(64'(acc), OW)) : '0;

endmodule

// File: tb/tb_srrc_interp.sv
// Randomised and directed check of srrc_interp against a sample-queue reference model.
module tb_srrc_interp;
    import srrc_pkg::*;

    localparam int NTAPS = 33;
    localparam int OSR   = 4;
    localparam int CW    = 16;
    localparam int OW    = 18;
    localparam int NPH   = 9;
    localparam int TAW   = 6;
    localparam int OMAX  = 131071;
    localparam int OMIN  = -131072;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      in_sym;
    logic            out_valid;
    logic            out_ready;
    logic [OW-1:0]   out_data;
    logic            coef_we;
    logic [TAW-1:0]  coef_addr;
    logic [CW-1:0]   coef_wdata;
    logic            flush;

    int checks = 0;
    int errors = 0;

    int         h    [NTAPS];
    int         hist [NPH];
    int         q    [$];
    logic [1:0] sq   [$];
    bit         last_in_fire;

    srrc_interp dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sym     (in_sym),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
        .flush      (flush)
    );

    always #5 clk = ~clk;

    function automatic int sym_val(input logic [1:0] s);
        case (s)
            2'b01:   return 1;
            2'b11:   return -1;
            2'b10:   return -2;
            default: return 0;
        endcase
    endfunction

    // Sample p of the newest symbol: sum over the symbol history of every OSR-th tap.
    function automatic int expect_sample(input int p);
        int sum;
        sum = 0;
        for (int k = 0; k < NPH; k++) begin
            if (p + OSR * k < NTAPS) begin
                sum += h[p + OSR * k] * hist[k];
            end
        end
        if (sum > OMAX) sum = OMAX;
        if (sum < OMIN) sum = OMIN;
        return sum;
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic clear_model(input bit coefs_too);
        q.delete();
        for (int k = 0; k < NPH; k++) hist[k] = 0;
        if (coefs_too) begin
            for (int i = 0; i < NTAPS; i++) h[i] = 0;
        end
    endtask

    // One clock: drive, check combinational outputs, take the edge, update the model.
    task automatic cyc(input logic iv, input logic [1:0] s, input logic ordy, input logic fl);
        bit ev, er, ifire, ofire;
        in_valid  = iv;
        in_sym    = s;
        out_ready = ordy;
        flush     = fl;
        #1;
        ev = (q.size() > 0);
        er = (q.size() == 0) || (q.size() == 1 && ordy);
        chk("out_valid", out_valid, ev);
        if (!fl) chk("in_ready", in_ready, er);
        if (ev) chk("out_data", $signed(out_data), q[0]);
        ifire = iv && er && !fl;
        ofire = ev && ordy && !fl;
        @(posedge clk);
        if (fl) begin
            clear_model(1'b0);
        end else begin
            if (ofire) void'(q.pop_front());
            if (ifire) begin
                for (int k = NPH - 1; k > 0; k--) hist[k] = hist[k-1];
                hist[0] = sym_val(s);
                for (int p = 0; p < OSR; p++) q.push_back(expect_sample(p));
            end
        end
        last_in_fire = ifire;
        #1;
    endtask

    task automatic wr(input int a, input int v);
        coef_we    = 1'b1;
        coef_addr  = TAW'(a);
        coef_wdata = CW'(v);
        cyc(1'b0, 2'b00, 1'b1, 1'b0);
        coef_we    = 1'b0;
        if (a < NTAPS) h[a] = v;
    endtask

    task automatic push_impulse(input logic [1:0] s);
        sq.push_back(s);
        repeat (NPH - 1) sq.push_back(SYM_ZERO);
    endtask

    // mode 0: both handshakes held high; mode 1: random input gaps and output stalls.
    task automatic stream(input int mode);
        int budget;
        budget = 0;
        while ((sq.size() > 0 || q.size() > 0) && budget < 3000) begin
            logic       iv;
            logic       ordy;
            logic [1:0] s;
            iv   = (sq.size() > 0);
            s    = SYM_ZERO;
            if (iv) s = sq[0];
            ordy = 1'b1;
            if (mode == 1) begin
                if ($urandom_range(0, 3) == 0) iv = 1'b0;
                ordy = ($urandom_range(0, 3) != 0);
            end
            cyc(iv, s, ordy, 1'b0);
            if (last_in_fire) void'(sq.pop_front());
            budget++;
        end
        chk("stream_budget", (budget < 3000), 1);
    endtask

    initial begin
        reset      = 1'b0;
        in_valid   = 1'b0;
        in_sym     = 2'b00;
        out_ready  = 1'b1;
        flush      = 1'b0;
        coef_we    = 1'b0;
        coef_addr  = '0;
        coef_wdata = '0;
        clear_model(1'b1);

        #3;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_data", $signed(out_data), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Ramp coefficients h[i]=i+1, plus a write past the last tap that must be ignored.
        for (int i = 0; i < NTAPS; i++) wr(i, i + 1);
        wr(35, 4660);

        push_impulse(SYM_P1);
        stream(0);
        push_impulse(SYM_M2);
        stream(0);
        push_impulse(SYM_M1);
        stream(0);

        // Stall three cycles at phase 2 of a lone +1 symbol.
        cyc(1'b1, SYM_P1, 1'b1, 1'b0);
        cyc(1'b0, SYM_ZERO, 1'b1, 1'b0);
        cyc(1'b0, SYM_ZERO, 1'b1, 1'b0);
        repeat (3) cyc(1'b0, SYM_ZERO, 1'b0, 1'b0);
        repeat (3) cyc(1'b0, SYM_ZERO, 1'b1, 1'b0);

        repeat (60) sq.push_back(2'($urandom_range(0, 3)));
        stream(1);

        // Asynchronous reset in the middle of a stream wipes coefficients too.
        repeat (10) cyc(1'b1, 2'($urandom_range(0, 3)), 1'b1, 1'b0);
        in_valid = 1'b0;
        reset    = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_data", $signed(out_data), 0);
        clear_model(1'b1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        push_impulse(SYM_P1);
        stream(0);

        // Saturation at both rails.
        for (int i = 0; i < NTAPS; i++) wr(i, 32767);
        repeat (NPH) sq.push_back(SYM_P1);
        stream(0);
        repeat (NPH) sq.push_back(SYM_M2);
        stream(0);

        // Random signed coefficients with random traffic.
        for (int i = 0; i < NTAPS; i++) wr(i, int'($urandom_range(0, 65535)) - 32768);
        repeat (80) sq.push_back(2'($urandom_range(0, 3)));
        stream(1);

        // Flush mid-run while a symbol is offered; the following impulse must be clean.
        for (int i = 0; i < NTAPS; i++) wr(i, i + 1);
        repeat (10) cyc(1'b1, 2'($urandom_range(0, 3)), 1'b1, 1'b0);
        cyc(1'b1, SYM_M2, 1'b1, 1'b1);
        cyc(1'b0, SYM_ZERO, 1'b1, 1'b0);
        push_impulse(SYM_P1);
        stream(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
